// File: rtl/count_seq_monitor.sv
// Checks that a sampled count bus advances by +1 modulo 2^WIDTH, counts wraps and faults.
// Optional WRAP_CMP_EN adds a wrap_target compare with a one-cycle wrap_hit pulse.
module count_seq_monitor #(
    parameter int WIDTH      = 3,
    parameter int WRAP_CNT_W = 8,
    parameter int ERR_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  count_vld,
    input  logic                  err_clr,
    output logic                  locked,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  seq_err,
    output logic                  seq_err_sticky,
    output logic [ERR_CNT_W-1:0]  err_count
`ifdef WRAP_CMP_EN
    ,
    input  logic [WRAP_CNT_W-1:0] wrap_target,
    output logic                  wrap_hit
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_prev;
    logic                  r_locked;
    logic                  r_wrap_pulse;
    logic [WRAP_CNT_W-1:0] r_wrap_count;
    logic                  r_seq_err;
    logic                  r_sticky;
    logic [ERR_CNT_W-1:0]  r_err_count;
    logic                  r_wrap_hit;

    logic [WIDTH-1:0]      w_next;
    logic                  w_prev_max;
    logic                  w_in_zero;
    logic                  w_wrap;
    logic                  w_inc;
    logic                  w_restart;
    logic                  w_wc_sat;
    logic                  w_ec_sat;
    logic [WRAP_CNT_W-1:0] w_wc_next;
    logic                  w_hit;

    // Wrap is tested before +1 because MAX+1 also equals zero.
    assign w_next     = r_prev + WIDTH'(1);
    assign w_prev_max = (r_prev == '1);
    assign w_in_zero  = (count_in == '0);
    assign w_wrap     = w_prev_max && w_in_zero;
    assign w_inc      = (count_in == w_next) && !w_wrap;
    assign w_restart  = w_in_zero && !w_prev_max;
    assign w_wc_sat   = (r_wrap_count == '1);
    assign w_ec_sat   = (r_err_count == '1);
    assign w_wc_next  = r_wrap_count + WRAP_CNT_W'(1);

`ifdef WRAP_CMP_EN
    assign w_hit = !w_wc_sat && (w_wc_next == wrap_target);
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_prev       <= '0;
            r_locked     <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= '0;
            r_seq_err    <= 1'b0;
            r_sticky     <= 1'b0;
            r_err_count  <= '0;
            r_wrap_hit   <= 1'b0;
        end else begin
            r_wrap_pulse <= 1'b0;
            r_seq_err    <= 1'b0;
            r_wrap_hit   <= 1'b0;

            if (err_clr) begin
                r_sticky    <= 1'b0;
                r_err_count <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (count_vld) begin
                        r_prev   <= count_in;
                        r_state  <= LOCK;
                        r_locked <= 1'b1;
                    end
                end
                LOCK: begin
                    if (count_vld) begin
                        if (w_wrap) begin
                            r_prev       <= '0;
                            r_wrap_pulse <= 1'b1;
                            r_wrap_hit   <= w_hit;
                            if (!w_wc_sat)
                                r_wrap_count <= w_wc_next;
                        end else if (w_inc || w_restart) begin
                            r_prev <= count_in;
                        end else begin
                            // A fault outranks a same-cycle clear.
                            r_seq_err <= 1'b1;
                            r_sticky  <= 1'b1;
                            r_state   <= FAULT;
                            r_locked  <= 1'b0;
                            if (err_clr)
                                r_err_count <= ERR_CNT_W'(1);
                            else if (!w_ec_sat)
                                r_err_count <= r_err_count + ERR_CNT_W'(1);
                        end
                    end
                end
                FAULT: begin
                    if (err_clr)
                        r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign locked         = r_locked;
    assign wrap_pulse     = r_wrap_pulse;
    assign wrap_count     = r_wrap_count;
    assign seq_err        = r_seq_err;
    assign seq_err_sticky = r_sticky;
    assign err_count      = r_err_count;

`ifdef WRAP_CMP_EN
    assign wrap_hit = r_wrap_hit;
`else
    logic w_unused;
    assign w_unused = r_wrap_hit ^ w_hit;
`endif

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream consumer of the free-running up-counter's count bus.
- Each cycle it may sample the count value and check that it advances by exactly +1 modulo 2^WIDTH.
- Detects wrap-around (max -> 0) and counts wraps with saturation.
- Flags sequence faults and holds a fault state until software clears it; sits between the counter and status/debug logic.

Parameters:
- WIDTH, 3, width of the monitored count bus.
- WRAP_CNT_W, 8, width of the wrap counter.
- ERR_CNT_W, 4, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  count value from the upstream counter.
- count_vld  input  1  count_in is valid this cycle; when low, the sample is ignored.
- err_clr  input  1  clears the fault state, seq_err_sticky and err_count.
- locked  output  1  high while in state LOCK.
- wrap_pulse  output  1  one-cycle pulse per detected wrap.
- wrap_count  output  WRAP_CNT_W  number of wraps, saturating.
- seq_err  output  1  one-cycle pulse per sequence fault.
- seq_err_sticky  output  1  set on a fault; held until err_clr or rst.
- err_count  output  ERR_CNT_W  number of faults, saturating.

Behaviour:
- Fixed decisions: one clock; reset is synchronous and active-high; the clock port is named clk and the reset port is named rst.
- All outputs are registered. Effects of a sample taken at edge N are visible after edge N (1-cycle latency).
- Reset: state = IDLE, prev = 0. locked, wrap_pulse, seq_err, seq_err_sticky = 0. wrap_count = 0, err_count = 0.
- rst is checked at the clock edge and overrides all other inputs, including mid-operation.
- FSM states: IDLE, LOCK, FAULT.
- IDLE:
  - count_vld = 1: prev <= count_in, go to LOCK.
  - No wrap or error evaluation on this first sample.
- LOCK, with count_vld = 1 and MAX = 2^WIDTH - 1:
  - count_in == prev + 1 (no wrap): prev <= count_in, stay in LOCK.
  - prev == MAX and count_in == 0: wrap. wrap_pulse = 1 for one cycle; wrap_count += 1, saturating at all-ones; prev <= 0.
  - prev != MAX and count_in == 0: upstream restart. prev <= 0; no wrap, no error; stay in LOCK.
  - Any other value, including a repeat of prev: fault. seq_err = 1 for one cycle, seq_err_sticky <= 1, err_count += 1 (saturating), go to FAULT. prev is not updated.
- LOCK, with count_vld = 0: hold; no pulses.
- FAULT:
  - count_vld samples are ignored; wrap_count is frozen.
  - err_clr = 1: go to IDLE.
- err_clr in any state:
  - Clears seq_err_sticky and err_count to 0.
  - In LOCK it does not change the state.
  - If a fault is detected in the same cycle as err_clr in LOCK, the fault wins: sticky = 1, err_count = 1, state goes to FAULT.
- err_clr and count_vld together in FAULT: clear wins, the sample is discarded, state goes to IDLE.
- locked = 1 exactly when state == LOCK (registered).
- wrap_pulse and seq_err are never high in the same cycle.
- Arithmetic on prev + 1 is modulo 2^WIDTH. Both counters saturate and never wrap.

Optional Feature:
- Macro: WRAP_CMP_EN.
- When defined:
  - Adds input wrap_target [WRAP_CNT_W-1:0] and output wrap_hit [1].
  - wrap_hit pulses for one cycle, aligned with wrap_pulse, on the wrap whose increment makes wrap_count equal wrap_target.
  - Saturation without a value change does not re-fire it.
  - wrap_hit resets to 0.
- When undefined: neither port exists and the behaviour is otherwise identical.

Test Plan:
- Wrap detection: rst = 1 for 3 cycles, then count_vld = 1 with count_in = 0,1,...,7,0. Expect locked = 1 from the cycle after the first sample, a single wrap_pulse after the final 0, wrap_count = 1, seq_err never asserted.
- Upstream restart: samples 0,1,2,0,1. Expect no seq_err, no wrap_pulse, locked held at 1, wrap_count = 0.
- Sequence fault: samples 3,4,6,7,0. Expect seq_err pulse after 6, seq_err_sticky = 1, err_count = 1, locked = 0. The subsequent 7,0 produce no wrap_pulse; wrap_count is unchanged.
- Clear from FAULT: while in FAULT, drive err_clr = 1 with count_vld = 1 and count_in = 5. Expect IDLE, sticky = 0, err_count = 0. Then samples 2,3 lock cleanly with locked = 1.
- Saturation and mid-run reset: with WRAP_CNT_W = 4, run 20 full wraps and expect wrap_count = 15 and held. Then rst = 1 mid-LOCK and expect every output to be 0 after that edge.
- Compare feature (WRAP_CMP_EN defined): wrap_target = 2. Expect wrap_hit only on the 2nd wrap, coincident with wrap_pulse; no hit on wraps 3 and later.
